// File: rtl/button_reset_ctrl_if.sv
// Signal bundle between button_reset_ctrl (slave) and the board/CPU side (master).
interface button_reset_ctrl_if;
  logic [2:0] BUTTON;
  logic       cpuNRst;
  logic [2:0] btnLevel;
  logic [2:0] btnPress;
  logic [1:0] state;

  modport master (output BUTTON, input cpuNRst, btnLevel, btnPress, state);
  modport slave  (input BUTTON, output cpuNRst, btnLevel, btnPress, state);
endinterface

// File: rtl/button_reset_ctrl.sv
// Debounces three active-low buttons and drives cpuNRst through a HALT/RUN/PULSE FSM.
// Define POWERON_RUN_EN to come out of reset in RUN instead of HALT.
module button_reset_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned RST_HOLD_CYCLES = 16
) (
  input logic                clk,
  input logic                nRst,
  button_reset_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    StHalt  = 2'b00,
    StRun   = 2'b01,
    StPulse = 2'b10
  } state_e;

`ifdef POWERON_RUN_EN
  localparam state_e ResetState = StRun;
`else
  localparam state_e ResetState = StHalt;
`endif

  localparam logic [CNT_W-1:0] DbLast   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};

  logic [2:0]       r_sync1, r_sync2;
  logic [2:0]       r_level, w_level_next;
  logic [2:0]       r_press, w_press_next;
  logic [CNT_W-1:0] r_dbcnt      [3];
  logic [CNT_W-1:0] w_dbcnt_next [3];

  state_e           r_state, w_state_next;
  logic [CNT_W-1:0] r_hold, w_hold_next;
  logic             r_cpu_nrst;

  // Level flips on the cycle the counter would reach DEBOUNCE_CYCLES; press is registered with it
  // so the edge-to-press latency is exactly DEBOUNCE_CYCLES+2.
  always_comb begin
    w_level_next = r_level;
    for (int i = 0; i < 3; i++) begin
      w_dbcnt_next[i] = '0;
      if (r_sync2[i] != r_level[i]) begin
        if (r_dbcnt[i] >= DbLast) begin
          w_level_next[i] = r_sync2[i];
        end else if (r_dbcnt[i] != CntMax) begin
          w_dbcnt_next[i] = r_dbcnt[i] + CNT_W'(1);
        end else begin
          w_dbcnt_next[i] = r_dbcnt[i];
        end
      end
    end
  end

  assign w_press_next = r_level & ~w_level_next;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_level <= '1;
      r_press <= '0;
      for (int i = 0; i < 3; i++) begin
        r_dbcnt[i] <= '0;
      end
    end else begin
      r_sync1 <= bus.BUTTON;
      r_sync2 <= r_sync1;
      r_level <= w_level_next;
      r_press <= w_press_next;
      for (int i = 0; i < 3; i++) begin
        r_dbcnt[i] <= w_dbcnt_next[i];
      end
    end
  end

  // Press priority: halt > run > pulse.
  always_comb begin
    w_state_next = r_state;
    w_hold_next  = r_hold;
    unique case (r_state)
      StHalt: begin
        if (!r_press[1] && r_press[0]) begin
          w_state_next = StRun;
        end
      end
      StRun: begin
        if (r_press[1]) begin
          w_state_next = StHalt;
        end else if (!r_press[0] && r_press[2]) begin
          w_state_next = StPulse;
          w_hold_next  = '0;
        end
      end
      StPulse: begin
        if (r_press[1]) begin
          w_state_next = StHalt;
        end else if (r_hold >= HoldLast) begin
          w_state_next = StRun;
        end else if (r_hold != CntMax) begin
          w_hold_next = r_hold + CNT_W'(1);
        end
      end
      default: w_state_next = StHalt;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state    <= ResetState;
      r_hold     <= '0;
      r_cpu_nrst <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_hold     <= w_hold_next;
      r_cpu_nrst <= (w_state_next == StRun);
    end
  end

  assign bus.cpuNRst  = r_cpu_nrst;
  assign bus.btnLevel = r_level;
  assign bus.btnPress = r_press;
  assign bus.state    = r_state;

endmodule

// File: tb/tb_button_reset_ctrl.sv
// Directed bench for button_reset_ctrl with DEBOUNCE_CYCLES=4, RST_HOLD_CYCLES=3.
module tb_button_reset_ctrl;

`ifdef POWERON_RUN_EN
  localparam logic [1:0] RstState = 2'b01;
  localparam logic       RstCpu   = 1'b1;
`else
  localparam logic [1:0] RstState = 2'b00;
  localparam logic       RstCpu   = 1'b0;
`endif

  logic clk;
  logic nRst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   lows;
  logic [2:0] acc;

  button_reset_ctrl_if u_if ();

  button_reset_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (4),
    .RST_HOLD_CYCLES(3)
  ) dut (
    .clk (clk),
    .nRst(nRst),
    .bus (u_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each tick samples #1 after the rising edge; inputs are also changed there.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_low(input int n);
    repeat (n) begin
      tick(1);
      if (u_if.cpuNRst === 1'b0) lows++;
    end
  endtask

  task automatic tick_acc(input int n);
    repeat (n) begin
      tick(1);
      acc = acc | u_if.btnPress;
    end
  endtask

  task automatic go_run(input string tag);
    u_if.BUTTON = 3'b110;
    tick(7);
    chk(tag, u_if.state, 2'b01);
    u_if.BUTTON = 3'b111;
    tick(8);
  endtask

  initial begin
    nRst        = 1'b1;
    u_if.BUTTON = 3'b111;
    #1 nRst = 1'b0;
    #1;
    chk("rst_cpu", u_if.cpuNRst, 1'b0);
    chk("rst_level", u_if.btnLevel, 3'b111);
    chk("rst_press", u_if.btnPress, 3'b000);
    chk("rst_state", u_if.state, RstState);
    tick(2);
    chk("rst_hold_cpu", u_if.cpuNRst, 1'b0);
    nRst = 1'b1;
    tick(1);
    chk("rel_state", u_if.state, RstState);
    chk("rel_cpu", u_if.cpuNRst, RstCpu);

    // Run press: clean edge, press after 6 cycles, RUN on the 7th
    u_if.BUTTON = 3'b110;
    tick(5);
    chk("run_early_press", u_if.btnPress, 3'b000);
    chk("run_early_level", u_if.btnLevel, 3'b111);
    tick(1);
    chk("run_press", u_if.btnPress, 3'b001);
    chk("run_level", u_if.btnLevel, 3'b110);
    chk("run_state_pre", u_if.state, RstState);
    chk("run_cpu_pre", u_if.cpuNRst, RstCpu);
    tick(1);
    chk("run_state", u_if.state, 2'b01);
    chk("run_cpu", u_if.cpuNRst, 1'b1);
    chk("run_press_gone", u_if.btnPress, 3'b000);
    u_if.BUTTON = 3'b111;
    acc = '0;
    tick_acc(8);
    chk("release_no_press", acc, 3'b000);
    chk("release_level", u_if.btnLevel, 3'b111);

    // Bouncing halt button, then held low
    acc = '0;
    for (int k = 0; k < 10; k++) begin
      u_if.BUTTON = {1'b1, k[0], 1'b1};
      tick_acc(2);
    end
    chk("bounce_no_press", acc, 3'b000);
    chk("bounce_state", u_if.state, 2'b01);
    chk("bounce_cpu", u_if.cpuNRst, 1'b1);
    u_if.BUTTON = 3'b101;
    tick(5);
    chk("halt_early", u_if.btnPress, 3'b000);
    tick(1);
    chk("halt_press", u_if.btnPress, 3'b010);
    tick(1);
    chk("halt_state", u_if.state, 2'b00);
    chk("halt_cpu", u_if.cpuNRst, 1'b0);
    u_if.BUTTON = 3'b111;
    tick(8);
    chk("halt_stays", u_if.state, 2'b00);
    go_run("rerun1");

    // Pulse reset, with a raw re-press glitch during the pulse
    u_if.BUTTON = 3'b011;
    tick(6);
    chk("pulse_press", u_if.btnPress, 3'b100);
    chk("pulse_cpu_pre", u_if.cpuNRst, 1'b1);
    lows = 0;
    tick_low(1);
    chk("pulse_state", u_if.state, 2'b10);
    u_if.BUTTON = 3'b111;
    tick_low(1);
    u_if.BUTTON = 3'b011;
    tick_low(12);
    chk("pulse_lows", lows, 3);
    chk("pulse_back_run", u_if.state, 2'b01);
    u_if.BUTTON = 3'b111;
    tick(8);

    // Run press lands inside the pulse and must not shorten it
    u_if.BUTTON = 3'b011;
    tick(2);
    u_if.BUTTON = 3'b010;
    tick(4);
    chk("pr_press2", u_if.btnPress, 3'b100);
    lows = 0;
    tick_low(2);
    chk("pr_press0", u_if.btnPress, 3'b001);
    tick_low(12);
    chk("pr_lows", lows, 3);
    chk("pr_state", u_if.state, 2'b01);
    u_if.BUTTON = 3'b111;
    tick(8);

    // Halt press inside the pulse goes straight to HALT
    u_if.BUTTON = 3'b011;
    tick(2);
    u_if.BUTTON = 3'b001;
    tick(4);
    chk("ph_press2", u_if.btnPress, 3'b100);
    tick(2);
    chk("ph_press1", u_if.btnPress, 3'b010);
    chk("ph_in_pulse", u_if.state, 2'b10);
    tick(1);
    chk("ph_state", u_if.state, 2'b00);
    chk("ph_cpu", u_if.cpuNRst, 1'b0);
    tick(3);
    chk("ph_state_hold", u_if.state, 2'b00);
    u_if.BUTTON = 3'b111;
    tick(8);
    go_run("rerun2");

    // Run and halt pressed together: halt wins
    u_if.BUTTON = 3'b100;
    tick(6);
    chk("both_press", u_if.btnPress, 3'b011);
    tick(1);
    chk("both_state", u_if.state, 2'b00);
    chk("both_cpu", u_if.cpuNRst, 1'b0);
    u_if.BUTTON = 3'b111;
    tick(8);
    go_run("rerun3");

    // Asynchronous reset mid-pulse and mid-debounce
    u_if.BUTTON = 3'b011;
    tick(7);
    chk("ar_pulse", u_if.state, 2'b10);
    u_if.BUTTON = 3'b010;
    tick(1);
    #2 nRst = 1'b0;
    #1;
    chk("ar_cpu", u_if.cpuNRst, 1'b0);
    chk("ar_state", u_if.state, RstState);
    chk("ar_level", u_if.btnLevel, 3'b111);
    chk("ar_press", u_if.btnPress, 3'b000);
    u_if.BUTTON = 3'b111;
    tick(2);
    nRst = 1'b1;
    acc = '0;
    tick_acc(10);
    chk("ar_no_press", acc, 3'b000);
    chk("ar_state_after", u_if.state, RstState);
    chk("ar_cpu_after", u_if.cpuNRst, RstCpu);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/button_reset_ctrl.md
BUTTON_RESET_CTRL -- requirements
Module: button_reset_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of consecutive stable synchronised samples needed to accept a button change (10 ms at 50 MHz).
REQ-002 Parameter CNT_W, default 20, is the width of the debounce and hold counters; it SHALL satisfy 2^CNT_W > max(DEBOUNCE_CYCLES, RST_HOLD_CYCLES).
REQ-003 Parameter RST_HOLD_CYCLES, default 16, is the number of cycles cpuNRst is held low for a pulse reset.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-005 Port nRst, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port BUTTON, input, 3 bits: raw active-low board buttons, asynchronous to clk. Bit 0 is run, bit 1 is halt, bit 2 is pulse-reset.
REQ-007 Port cpuNRst, output, 1 bit: active-low reset driven to CPU and MMU.
REQ-008 Port btnLevel, output, 3 bits: debounced button levels, active-low.
REQ-009 Port btnPress, output, 3 bits: one-cycle pulse per bit on each debounced press.
REQ-010 Port state, output, 2 bits: FSM encoding, HALT=00, RUN=01, PULSE=10.

Function
REQ-011 Each BUTTON bit SHALL pass through a two-flop synchroniser before any other use.
REQ-012 Per bit: while the synchronised value differs from btnLevel, the counter increments. When it would reach DEBOUNCE_CYCLES, btnLevel takes the synchronised value and the counter clears. Any cycle with the synchronised value equal to btnLevel clears the counter.
REQ-013 btnPress[i] SHALL be 1 for exactly the one cycle after btnLevel[i] changes 1->0. It is never asserted on release.
REQ-014 Latency from a clean BUTTON edge to btnPress SHALL be DEBOUNCE_CYCLES+2 cycles, constant.
REQ-015 HALT: cpuNRst=0. btnPress[0] moves to RUN. btnPress[2] is ignored.
REQ-016 RUN: cpuNRst=1. btnPress[1] moves to HALT. Otherwise btnPress[2] moves to PULSE and loads the hold counter with 0.
REQ-017 PULSE: cpuNRst=0 while the hold counter increments. On reaching RST_HOLD_CYCLES-1 the FSM returns to RUN, giving exactly RST_HOLD_CYCLES low cycles. btnPress[1] in PULSE moves to HALT immediately. btnPress[0] and btnPress[2] are ignored, so there is no retrigger.
REQ-018 Simultaneous presses in one cycle SHALL follow the priority halt > run > pulse.
REQ-019 cpuNRst SHALL be a registered output with no combinational path from any input.
REQ-020 The counters SHALL saturate, never wrap; an unreachable state encoding (11) SHALL go to HALT.

Reset
REQ-021 While nRst=0: cpuNRst=0, btnLevel=3'b111, btnPress=0, synchroniser flops=1, all counters=0, state=HALT (or RUN per REQ-023). Asserting nRst takes effect asynchronously, without waiting for a clock edge.
REQ-022 Reset asserted mid-PULSE or mid-debounce SHALL abandon the operation, and no pulse SHALL be emitted after reset release.

Configuration
REQ-023 Macro POWERON_RUN_EN: when defined, the FSM resets into RUN, so cpuNRst=1 on the first clock after nRst deasserts. When undefined, the FSM resets into HALT and waits for btnPress[0].

Verification (DEBOUNCE_CYCLES=4, RST_HOLD_CYCLES=3)
REQ-024 BUTTON[0] driven low and held, macro undefined -> btnPress[0] pulses at cycle 6, then state=01 and cpuNRst=1 on the following cycle.
REQ-025 In RUN, BUTTON[1] toggles every 2 cycles for 20 cycles, then is held low -> no btnPress during the bounce; one btnPress[1] 6 cycles after the last edge; state=00.
REQ-026 In RUN, BUTTON[2] pressed -> cpuNRst low for exactly 3 cycles, then state=01; a second press during PULSE produces no extra low cycles.
REQ-027 BUTTON[0] and BUTTON[1] released to pressed in the same cycle from RUN -> state=00, cpuNRst=0.
REQ-028 nRst pulsed low during PULSE -> cpuNRst=0 with no clock edge; after release, state=00 (macro undefined) or 01 (macro defined), and btnPress=0.
